// File: rtl/riscv_core_id_stage.sv
// Queued, back-pressured RV32I decode stage: FIFO -> decode -> registered valid/ready output.
// Defining RISCV_CORE_ID_SCOREBOARD_EN adds a RAW/WAW register scoreboard with writeback clears.
module riscv_core_id_stage #(
  parameter int QUEUE_DEPTH = 2,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [4:0]      id_rsj,
  output logic [4:0]      id_rsk,
  output logic [4:0]      id_rd,
  output logic            id_rsj_valid,
  output logic            id_rsk_valid,
  output logic            id_rd_valid,
  output logic [31:0]     id_immed,
  output logic [9:0]      id_alu_funct,
  output logic [7:0]      id_mem_funct,
  output logic [6:0]      id_br_funct,
  output logic [PC_W-1:0] id_target,
  output logic            id_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [9:0] ALU_ADD    = 10'h001;
  localparam logic [6:0] BR_JUMP    = 7'h40;

  function automatic logic [9:0] alu_dec(input logic [9:0] key);
    case (key)
      10'b0000000_000: alu_dec = 10'h001;
      10'b0100000_000: alu_dec = 10'h002;
      10'b0000000_110: alu_dec = 10'h004;
      10'b0000000_100: alu_dec = 10'h008;
      10'b0000000_111: alu_dec = 10'h010;
      10'b0000000_010: alu_dec = 10'h020;
      10'b0000000_011: alu_dec = 10'h040;
      10'b0000000_001: alu_dec = 10'h080;
      10'b0000000_101: alu_dec = 10'h100;
      10'b0100000_101: alu_dec = 10'h200;
      default:         alu_dec = 10'h000;
    endcase
  endfunction

  // key[3] selects store encodings, key[2:0] is funct3
  function automatic logic [7:0] mem_dec(input logic [3:0] key);
    case (key)
      4'b0000: mem_dec = 8'h01;
      4'b0001: mem_dec = 8'h02;
      4'b0010: mem_dec = 8'h04;
      4'b0100: mem_dec = 8'h08;
      4'b0101: mem_dec = 8'h10;
      4'b1000: mem_dec = 8'h20;
      4'b1001: mem_dec = 8'h40;
      4'b1010: mem_dec = 8'h80;
      default: mem_dec = 8'h00;
    endcase
  endfunction

  function automatic logic [6:0] br_dec(input logic [2:0] f3);
    case (f3)
      3'b000:  br_dec = 7'h01;
      3'b001:  br_dec = 7'h02;
      3'b100:  br_dec = 7'h04;
      3'b101:  br_dec = 7'h08;
      3'b110:  br_dec = 7'h10;
      3'b111:  br_dec = 7'h20;
      default: br_dec = 7'h00;
    endcase
  endfunction

  logic [31:0]     q_instr [QUEUE_DEPTH];
  logic [PC_W-1:0] q_pc    [QUEUE_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            push, load_p0, head_vld_p0, stall;

  assign if_ready    = (count != CW'(QUEUE_DEPTH));
  assign push        = if_valid && if_ready && !flush;
  assign head_vld_p0 = (count != '0);
  assign load_p0     = head_vld_p0 && (!id_valid || id_ready) && !stall && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (load_p0) rd_ptr <= rd_ptr + 1'b1;
      if (push && !load_p0)      count <= count + 1'b1;
      else if (!push && load_p0) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= if_instr;
      q_pc[wr_ptr]    <= if_pc;
    end
  end

  // ---- stage p0: decode the queue head ----
  logic [31:0]     instr_p0, imm_i, imm_s, imm_u, imm_b, imm_j, imm_p0;
  logic [PC_W-1:0] pc_p0, tgt_p0;
  logic [6:0]      opc_p0, f7_p0, br_p0;
  logic [2:0]      f3_p0;
  logic [9:0]      alu_p0;
  logic [7:0]      mem_p0;
  logic            rsj_v_p0, rsk_v_p0, rd_v_p0, ill_p0, is_shift;

  assign instr_p0 = q_instr[rd_ptr];
  assign pc_p0    = q_pc[rd_ptr];
  assign opc_p0   = instr_p0[6:0];
  assign f3_p0    = instr_p0[14:12];
  assign f7_p0    = instr_p0[31:25];
  assign is_shift = (f3_p0 == 3'b001) || (f3_p0 == 3'b101);
  assign imm_i    = {{20{instr_p0[31]}}, instr_p0[31:20]};
  assign imm_s    = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
  assign imm_u    = {instr_p0[31:12], 12'h000};
  assign imm_b    = {{20{instr_p0[31]}}, instr_p0[7], instr_p0[30:25], instr_p0[11:8], 1'b0};
  assign imm_j    = {{12{instr_p0[31]}}, instr_p0[19:12], instr_p0[20], instr_p0[30:21], 1'b0};

  always_comb begin
    rsj_v_p0 = 1'b1;
    rsk_v_p0 = 1'b0;
    rd_v_p0  = 1'b0;
    imm_p0   = '0;
    alu_p0   = ALU_ADD;
    mem_p0   = '0;
    br_p0    = '0;
    tgt_p0   = '0;
    ill_p0   = 1'b0;
    case (opc_p0)
      OPC_OP: begin
        rsk_v_p0 = 1'b1;
        rd_v_p0  = 1'b1;
        alu_p0   = alu_dec({f7_p0, f3_p0});
        ill_p0   = (alu_p0 == '0);
      end
      OPC_OPIMM: begin
        rd_v_p0 = 1'b1;
        imm_p0  = imm_i;
        alu_p0  = alu_dec(is_shift ? {f7_p0, f3_p0} : {7'b0, f3_p0});
        ill_p0  = (alu_p0 == '0) || (is_shift && instr_p0[25]);
      end
      OPC_LUI, OPC_AUIPC: begin
        rsj_v_p0 = 1'b0;
        rd_v_p0  = 1'b1;
        imm_p0   = imm_u;
      end
      OPC_JAL: begin
        rsj_v_p0 = 1'b0;
        rd_v_p0  = 1'b1;
        imm_p0   = 32'd4;
        br_p0    = BR_JUMP;
        tgt_p0   = pc_p0 + imm_j[PC_W-1:0];
      end
      OPC_JALR: begin
        rd_v_p0 = 1'b1;
        imm_p0  = 32'd4;
        br_p0   = BR_JUMP;
        tgt_p0  = imm_i[PC_W-1:0];
        ill_p0  = (f3_p0 != 3'b000);
      end
      OPC_BRANCH: begin
        rsk_v_p0 = 1'b1;
        br_p0    = br_dec(f3_p0);
        tgt_p0   = pc_p0 + imm_b[PC_W-1:0];
        ill_p0   = (br_p0 == '0);
      end
      OPC_LOAD: begin
        rd_v_p0 = 1'b1;
        imm_p0  = imm_i;
        mem_p0  = mem_dec({1'b0, f3_p0});
        ill_p0  = (mem_p0 == '0);
      end
      OPC_STORE: begin
        rsk_v_p0 = 1'b1;
        imm_p0   = imm_s;
        mem_p0   = mem_dec({1'b1, f3_p0});
        ill_p0   = (mem_p0 == '0);
      end
      default: ill_p0 = 1'b1;
    endcase
    rd_v_p0 = rd_v_p0 && (instr_p0[11:7] != 5'd0);
    if (ill_p0) begin
      alu_p0   = '0;
      mem_p0   = '0;
      br_p0    = '0;
      rsj_v_p0 = 1'b0;
      rsk_v_p0 = 1'b0;
      rd_v_p0  = 1'b0;
    end
  end

`ifdef RISCV_CORE_ID_SCOREBOARD_EN
  logic [31:0] busy, set_mask, clr_mask;

  function automatic logic sb_hit(input logic [4:0] r);
    sb_hit = busy[r] || (id_valid && id_rd_valid && (id_rd == r));
  endfunction

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (id_valid && id_ready && id_rd_valid && !flush) set_mask[id_rd] = 1'b1;
    if (wb_valid) clr_mask[wb_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= ((busy & ~clr_mask) | set_mask) & ~32'h1;
  end

  assign stall = (rsj_v_p0 && sb_hit(instr_p0[19:15])) ||
                 (rsk_v_p0 && sb_hit(instr_p0[24:20])) ||
                 (rd_v_p0  && sb_hit(instr_p0[11:7]));
`else
  logic unused_wb;
  assign unused_wb = wb_valid ^ (^wb_rd);
  assign stall     = 1'b0;
`endif

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_rsj       <= '0;
      id_rsk       <= '0;
      id_rd        <= '0;
      id_rsj_valid <= 1'b0;
      id_rsk_valid <= 1'b0;
      id_rd_valid  <= 1'b0;
      id_immed     <= '0;
      id_alu_funct <= '0;
      id_mem_funct <= '0;
      id_br_funct  <= '0;
      id_target    <= '0;
      id_illegal   <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load_p0) begin
      id_valid     <= 1'b1;
      id_pc        <= pc_p0;
      id_rsj       <= instr_p0[19:15];
      id_rsk       <= instr_p0[24:20];
      id_rd        <= instr_p0[11:7];
      id_rsj_valid <= rsj_v_p0;
      id_rsk_valid <= rsk_v_p0;
      id_rd_valid  <= rd_v_p0;
      id_immed     <= imm_p0;
      id_alu_funct <= alu_p0;
      id_mem_funct <= mem_p0;
      id_br_funct  <= br_p0;
      id_target    <= tgt_p0;
      id_illegal   <= ill_p0;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_riscv_core_id_stage.sv
// Bench for riscv_core_id_stage: directed decode/flow cases plus a randomized stream against a queue model.
module tb_riscv_core_id_stage;
  localparam int QD   = 2;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst, flush, if_valid, id_ready, wb_valid;
  logic            if_ready, id_valid;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc, id_pc, id_target;
  logic [4:0]      id_rsj, id_rsk, id_rd, wb_rd;
  logic            id_rsj_valid, id_rsk_valid, id_rd_valid, id_illegal;
  logic [31:0]     id_immed;
  logic [9:0]      id_alu_funct;
  logic [7:0]      id_mem_funct;
  logic [6:0]      id_br_funct;

  riscv_core_id_stage #(.QUEUE_DEPTH(QD), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rsj(id_rsj), .id_rsk(id_rsk), .id_rd(id_rd),
    .id_rsj_valid(id_rsj_valid), .id_rsk_valid(id_rsk_valid), .id_rd_valid(id_rd_valid),
    .id_immed(id_immed), .id_alu_funct(id_alu_funct), .id_mem_funct(id_mem_funct),
    .id_br_funct(id_br_funct), .id_target(id_target), .id_illegal(id_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        rsj_v, rsk_v, rd_v, ill;
    logic [4:0]  rsj, rsk, rd;
    logic [31:0] imm, tgt;
    logic [9:0]  alu;
    logic [7:0]  mem;
    logic [6:0]  br;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  item_t mq[$];
  item_t m_out;
  bit    m_outv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: classify by opcode, then look mnemonics up in ordered tables.
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    logic [9:0] alu_codes [10] = '{10'h000, 10'h100, 10'h006, 10'h004, 10'h007,
                                   10'h002, 10'h003, 10'h001, 10'h005, 10'h105};
    int ld_f3 [5] = '{0, 1, 2, 4, 5};
    int st_f3 [3] = '{0, 1, 2};
    int br_f3 [6] = '{0, 1, 4, 5, 6, 7};
    int f3, ii, si, bi, ji;
    logic [9:0] key;
    f3 = int'(w[14:12]);
    ii = $signed(w[31:20]);
    si = $signed({w[31:25], w[11:7]});
    bi = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    ji = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    d = '0;
    d.pc = pc; d.rsj = w[19:15]; d.rsk = w[24:20]; d.rd = w[11:7];
    d.alu = 10'h001;
    key = {w[31:25], w[14:12]};
    case (w[6:0])
      7'h33: begin
        d.rsj_v = 1; d.rsk_v = 1; d.rd_v = 1; d.alu = 0;
        for (int i = 0; i < 10; i++) if (alu_codes[i] == key) d.alu = 10'(1) << i;
        d.ill = (d.alu == 0);
      end
      7'h13: begin
        d.rsj_v = 1; d.rd_v = 1; d.imm = ii; d.alu = 0;
        if (!(f3 == 1 || f3 == 5)) key = {7'b0, w[14:12]};
        for (int i = 0; i < 10; i++) if (alu_codes[i] == key) d.alu = 10'(1) << i;
        d.ill = (d.alu == 0) || ((f3 == 1 || f3 == 5) && w[25]);
      end
      7'h37, 7'h17: begin d.rd_v = 1; d.imm = {w[31:12], 12'h0}; end
      7'h6f: begin d.rd_v = 1; d.imm = 4; d.br = 7'h40; d.tgt = pc + ji; end
      7'h67: begin
        d.rsj_v = 1; d.rd_v = 1; d.imm = 4; d.br = 7'h40; d.tgt = ii; d.ill = (f3 != 0);
      end
      7'h63: begin
        d.rsj_v = 1; d.rsk_v = 1; d.tgt = pc + bi;
        for (int i = 0; i < 6; i++) if (br_f3[i] == f3) d.br = 7'(1) << i;
        d.ill = (d.br == 0);
      end
      7'h03: begin
        d.rsj_v = 1; d.rd_v = 1; d.imm = ii;
        for (int i = 0; i < 5; i++) if (ld_f3[i] == f3) d.mem = 8'(1) << i;
        d.ill = (d.mem == 0);
      end
      7'h23: begin
        d.rsj_v = 1; d.rsk_v = 1; d.imm = si;
        for (int i = 0; i < 3; i++) if (st_f3[i] == f3) d.mem = 8'(1) << (i + 5);
        d.ill = (d.mem == 0);
      end
      default: d.ill = 1;
    endcase
    if (d.rd == 0) d.rd_v = 0;
    if (d.ill) begin
      d.alu = 0; d.mem = 0; d.br = 0; d.rsj_v = 0; d.rsk_v = 0; d.rd_v = 0;
    end
    return d;
  endfunction

  task automatic cmp_dec(input string t, input dec_t d);
    check({t, ".pc"},   id_pc, d.pc);
    check({t, ".ill"},  id_illegal, d.ill);
    check({t, ".alu"},  id_alu_funct, d.alu);
    check({t, ".mem"},  id_mem_funct, d.mem);
    check({t, ".br"},   id_br_funct, d.br);
    check({t, ".rsjv"}, id_rsj_valid, d.rsj_v);
    check({t, ".rskv"}, id_rsk_valid, d.rsk_v);
    check({t, ".rdv"},  id_rd_valid, d.rd_v);
    if (!d.ill) begin
      check({t, ".imm"}, id_immed, d.imm);
      check({t, ".tgt"}, id_target, d.tgt);
    end
    if (d.rsj_v) check({t, ".rsj"}, id_rsj, d.rsj);
    if (d.rsk_v) check({t, ".rsk"}, id_rsk, d.rsk);
    if (d.rd_v)  check({t, ".rd"},  id_rd, d.rd);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) begin
      w[6:0] = ops[sel];
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if (sel == 5 && $urandom_range(0, 1) != 0) w[14:12] = 3'b000;
    end
`ifdef RISCV_CORE_ID_SCOREBOARD_EN
    w[11:7] = 5'd0;
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; if_valid = 0; id_ready = 0; wb_valid = 0; wb_rd = 0;
    if_instr = 0; if_pc = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
    if_valid = 1; if_instr = w; if_pc = pc;
    tick();
    if_valid = 0;
  endtask

  task automatic issue_one(input logic [31:0] w, input logic [31:0] pc);
    do_reset();
    id_ready = 0;
    push_one(w, pc);
    tick();
  endtask

  // Cycle model of queue + output slot, advanced once per clock edge.
  task automatic model_edge();
    bit ps, ld, hs;
    if (flush) begin
      mq.delete();
      m_outv = 0;
    end else begin
      ps = if_valid && (mq.size() != QD);
      ld = (mq.size() > 0) && (!m_outv || id_ready);
      hs = m_outv && id_ready;
      if (ld) begin
        m_out  = mq.pop_front();
        m_outv = 1;
      end else if (hs) begin
        m_outv = 0;
      end
      if (ps) mq.push_back('{if_instr, if_pc});
    end
  endtask

  task automatic model_checks(input string t);
    check({t, ".if_ready"}, if_ready, (mq.size() != QD));
    check({t, ".id_valid"}, id_valid, m_outv);
    if (m_outv && id_valid) cmp_dec(t, ref_decode(m_out.instr, m_out.pc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [31:0] got_imm [$];

    // Reset state
    do_reset();
    check("rst.id_valid", id_valid, 0);
    check("rst.if_ready", if_ready, 1);
    check("rst.id_pc", id_pc, 0);
    check("rst.immed", id_immed, 0);
    check("rst.alu", id_alu_funct, 0);
    check("rst.target", id_target, 0);
    check("rst.rd_valid", id_rd_valid, 0);

    // ADDI x1,x0,5 with two-edge latency and hold under back-pressure
    id_ready = 0;
    push_one(32'h00500093, 32'h100);
    check("addi.early", id_valid, 0);
    tick();
    check("addi.valid", id_valid, 1);
    check("addi.alu", id_alu_funct, 10'h001);
    check("addi.immed", id_immed, 5);
    check("addi.rd", id_rd, 1);
    check("addi.rd_valid", id_rd_valid, 1);
    check("addi.rsk_valid", id_rsk_valid, 0);
    cmp_dec("addi", ref_decode(32'h00500093, 32'h100));
    tick();
    check("addi.hold_valid", id_valid, 1);
    check("addi.hold_immed", id_immed, 5);
    id_ready = 1;
    tick();
    check("addi.consumed", id_valid, 0);

    // Back-to-back stream with execute stalled
    do_reset();
    id_ready = 0; accepted = 0;
    for (int c = 0; c < 6; c++) begin
      if_valid = 1; if_instr = 32'h00000013 | ((accepted + 1) << 20); if_pc = 32'h1000 + 4 * accepted;
      if (if_ready) accepted++;
      tick();
    end
    if_valid = 0;
    check("b2b.accepted", accepted, 3);
    check("b2b.if_ready", if_ready, 0);
    check("b2b.id_valid", id_valid, 1);
    id_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (id_valid) got_imm.push_back(id_immed);
      tick();
    end
    check("b2b.drain_count", got_imm.size(), 3);
    for (int i = 0; i < 3 && i < got_imm.size(); i++) check("b2b.order", got_imm[i], i + 1);

    // BEQ backwards and JAL forwards
    issue_one(32'hFE000EE3, 32'h200);
    check("beq.br", id_br_funct, 7'h01);
    check("beq.target", id_target, 32'h1FC);
    check("beq.alu", id_alu_funct, 10'h001);
    cmp_dec("beq", ref_decode(32'hFE000EE3, 32'h200));
    issue_one(32'h008000EF, 32'h300);
    check("jal.br", id_br_funct, 7'h40);
    check("jal.immed", id_immed, 4);
    check("jal.target", id_target, 32'h308);
    check("jal.rsj_valid", id_rsj_valid, 0);
    cmp_dec("jal", ref_decode(32'h008000EF, 32'h300));

    // Illegal encodings
    issue_one(32'h00000000, 32'h500);
    check("ill0.illegal", id_illegal, 1);
    check("ill0.alu", id_alu_funct, 0);
    issue_one(32'h02109093, 32'h504);
    check("illsh.illegal", id_illegal, 1);
    check("illsh.alu", id_alu_funct, 0);
    check("illsh.rd_valid", id_rd_valid, 0);
    issue_one(32'h000090E7, 32'h508);
    check("illjr.illegal", id_illegal, 1);
    check("illjr.br", id_br_funct, 0);
    check("illjr.rd_valid", id_rd_valid, 0);
    check("illjr.rsj_valid", id_rsj_valid, 0);
    // consume it while pushing ADDI x2,x1,0: x1 must not be marked busy
    id_ready = 1;
    if_valid = 1; if_instr = 32'h00008113; if_pc = 32'h50C;
    tick();
    if_valid = 0;
    tick();
    check("illjr.no_sb.valid", id_valid, 1);
    check("illjr.no_sb.pc", id_pc, 32'h50C);

    // RAW hazard: ADDI x3 then ADD x4,x3,x3
    do_reset();
    id_ready = 1;
    push_one(32'h00100193, 32'h400);
    push_one(32'h00318233, 32'h404);
    check("raw.first_valid", id_valid, 1);
    check("raw.first_pc", id_pc, 32'h400);
    tick();
`ifdef RISCV_CORE_ID_SCOREBOARD_EN
    check("raw.stall0", id_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("raw.stall", id_valid, 0);
    end
    wb_valid = 1; wb_rd = 3;
    tick();
    wb_valid = 0;
    check("raw.wb_cycle", id_valid, 0);
    tick();
    check("raw.release_valid", id_valid, 1);
    check("raw.release_pc", id_pc, 32'h404);
    check("raw.release_rsj", id_rsj, 3);
    check("raw.release_alu", id_alu_funct, 10'h001);
`else
    check("raw.no_stall_valid", id_valid, 1);
    check("raw.no_stall_pc", id_pc, 32'h404);
`endif

    // Flush with two queued entries and a held output
    do_reset();
    id_ready = 0;
    for (int k = 1; k <= 3; k++) push_one(32'h00000013 | (k << 20), 32'h800 + 4 * k);
    check("flush.pre_valid", id_valid, 1);
    check("flush.pre_if_ready", if_ready, 0);
    flush = 1; if_valid = 1; if_instr = 32'h00700013; if_pc = 32'h8F0;
    tick();
    flush = 0; if_valid = 0;
    check("flush.id_valid", id_valid, 0);
    check("flush.if_ready", if_ready, 1);
    push_one(32'h00900013, 32'h900);
    tick();
    check("flush.next_valid", id_valid, 1);
    check("flush.next_pc", id_pc, 32'h900);
    check("flush.next_imm", id_immed, 9);

    // Asynchronous reset between clock edges
    #2 rst = 1;
    #1;
    check("arst.id_valid", id_valid, 0);
    check("arst.if_ready", if_ready, 1);
    check("arst.id_pc", id_pc, 0);
    tick();
    rst = 0;

    // Randomized stream against the model
    do_reset();
    mq.delete();
    m_outv = 0;
    for (int c = 0; c < 400; c++) begin
      flush    = ($urandom_range(0, 49) == 0);
      if_valid = ($urandom_range(0, 9) < 7);
      id_ready = ($urandom_range(0, 9) < 6);
      if_instr = rand_instr();
      if_pc    = $urandom;
      model_checks("rnd");
      model_edge();
      tick();
    end
    flush = 0; if_valid = 0; id_ready = 1;
    for (int c = 0; c < QD + 4; c++) begin
      model_checks("drain");
      model_edge();
      tick();
    end
    check("drain.id_valid", id_valid, 0);
    check("drain.if_ready", if_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_core_id_stage.md
# riscv_core_id_stage

Registered, back-pressured RV32I decode stage, sitting between the fetch unit and the execute/issue stage of the core. An instruction queue of `QUEUE_DEPTH` entries absorbs fetch bursts. The head entry is decoded into one-hot ALU, memory and branch function codes, immediates and a PC-relative target, then held in an output register under a valid/ready handshake. An optional register scoreboard stalls on read-after-write (RAW) and write-after-write (WAW) hazards until writeback clears them.

## Interface
Parameters:
- `QUEUE_DEPTH`, 2: instruction queue entries; power of two, ≥2.
- `PC_W`, 32: PC and target width, ≤32.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `flush` in 1: discard all queued and output-registered instructions.
- `if_valid` in 1: fetch offers an instruction.
- `if_ready` out 1: queue can accept.
- `if_instr` in 32: instruction word.
- `if_pc` in `PC_W`: instruction PC.
- `id_valid` out 1: decoded instruction available.
- `id_ready` in 1: execute accepts.
- `id_pc` out `PC_W`: PC of the decoded instruction.
- `id_rsj`, `id_rsk`, `id_rd` out 5 each: register indices.
- `id_rsj_valid`, `id_rsk_valid`, `id_rd_valid` out 1 each: the corresponding field is used.
- `id_immed` out 32: immediate.
- `id_alu_funct` out 10: one-hot ALU op, bits 0..9 = ADD, SUB, OR, XOR, AND, SLT, SLTU, SLL, SRL, SRA.
- `id_mem_funct` out 8: one-hot memory op, bits 0..7 = LB, LH, LW, LBU, LHU, SB, SH, SW; 0 = none.
- `id_br_funct` out 7: one-hot branch op, bits 0..6 = BEQ, BNE, BLT, BGE, BLTU, BGEU, JUMP; 0 = none.
- `id_target` out `PC_W`: branch or jump target.
- `id_illegal` out 1: undecodable instruction.
- `wb_valid` in 1: writeback retires a destination register.
- `wb_rd` in 5: register being written back.

## Operation
**Queue**
- FIFO with separate read and write pointers plus a count.
- Push on `if_valid && if_ready`.
- Pop when the head moves into the output register.

**Output register load**
- Loads when the head is valid, the output register is empty or handshaking (`id_valid && id_ready`), and the head is not hazard-stalled.

**Decode**
- Opcode is the full 7 bits `instr[6:0]`.
- `rsj_valid` for every opcode except LUI, AUIPC and JAL.
- `rsk_valid` only for OP, BRANCH and STORE.
- `rd_valid` for OP, OP-IMM, LUI, AUIPC, JAL, JALR and LOAD, and only when `rd != 0`.

**Immediate selection**
- I-type for OP-IMM and LOAD.
- S-type for STORE.
- U-type for LUI and AUIPC.
- 4 for JAL and JALR (the link value).
- 0 otherwise.

**Function codes**
- OP: decode `{funct7, funct3}`.
- OP-IMM: decode `{7'b0, funct3}`, except funct3 = 001 or 101, which decode `{funct7, funct3}`.
- All other opcodes set `alu_funct = ADD`.
- LOAD and STORE decode `funct3` into `id_mem_funct`.
- BRANCH decodes `funct3` into `id_br_funct`; JAL and JALR set JUMP.

**Target**
- BRANCH: `pc + B-imm`.
- JAL: `pc + J-imm`.
- JALR: I-imm (execute adds rs1 and clears bit 0).
- Otherwise 0.
- Arithmetic is modulo 2^`PC_W`; the immediate is truncated to `PC_W`.

**Illegal instructions**
- Conditions that set `id_illegal`:
  - unknown opcode;
  - OP or OP-IMM whose ALU decode is 0;
  - LOAD or STORE whose memory decode is 0;
  - BRANCH whose branch decode is 0;
  - JALR with `funct3 != 0`;
  - OP-IMM shift with `instr[25] = 1`.
- An illegal instruction still flows through with `id_illegal = 1`, all function outputs 0 and all `*_valid = 0`.

**Flush**
- In the flush cycle:
  - the input handshake is ignored;
  - the queue empties;
  - the output register is invalidated at the next edge;
  - any output handshake in that cycle is void and must be discarded by execute.

## Timing
- Reset:
  - queue empty;
  - `id_valid = 0`;
  - all `id_*` data outputs 0;
  - scoreboard clear;
  - `if_ready = 1` (it is a function of count only).
- Latency: an instruction pushed at edge N appears on `id_valid` after edge N+1.
- Throughput: one instruction per cycle with no hazards.
- `if_ready = (count != QUEUE_DEPTH)`. A pop in the same cycle does not make room: no push-through when full.
- Simultaneous push and pop keeps count unchanged. Pointers wrap modulo `QUEUE_DEPTH`.
- `id_*` outputs hold stable while `id_valid && !id_ready`.
- `flush` overrides simultaneous push, pop, load and handshake. `wb` clears still apply.
- `rst` asserted mid-operation returns every state element to its reset value immediately (asynchronously).

## Configuration
Macro: `RISCV_CORE_ID_SCOREBOARD_EN`.

Defined:
- 32-bit busy vector; bit 0 is never set.
- A bit is set on an output handshake with `id_rd_valid`, and cleared on `wb_valid` for `wb_rd`.
- A set and a clear of the same bit in the same cycle: the set wins.
- The head stalls if its rsj, rsk or rd (when valid) is busy, or matches a valid output-register `id_rd` with `id_rd_valid`.
- A writeback in the same cycle as the check does not unstall until the next cycle.
- `flush` does not clear the scoreboard.

Undefined:
- No hazard stall; the `wb_*` inputs are ignored and consume no flops.

## Test plan
- Reset, then push `0x00500093` (ADDI x1,x0,5) at pc 0x100 → two cycles later: `id_valid = 1`, `alu_funct = 0x001`, `immed = 5`, `id_rd = 1`, `rd_valid = 1`, `rsk_valid = 0`.
- Back-to-back stream with `QUEUE_DEPTH = 2` and `id_ready` held low → `if_ready` drops after 2 queued plus 1 held; raising `id_ready` then drains in order with no loss or duplication.
- BEQ `0xFE000EE3` at pc 0x200 → `br_funct = 0x01`, `target = 0x1FC`; JAL `0x008000EF` → `br_funct = 0x40`, `immed = 4`, `target = pc + 8`.
- Illegal cases: `0x00000000`, OP-IMM SLLI with `instr[25] = 1`, JALR with `funct3 = 1` → `id_illegal = 1`, all functs 0, no scoreboard set.
- With the scoreboard macro: ADDI x3 issued, then ADD x4,x3,x3 → held until `wb_valid` with `wb_rd = 3`, then issues the following cycle.
- `flush` asserted while the queue holds 2 entries and `id_valid = 1` → next cycle `id_valid = 0`, queue empty, `if_ready = 1`.
